// File: rtl/mem_stage_pkg.sv
// Purpose : shared types, size codes and byte-enable generation for the memory stage.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Per-instruction memory controls held for the duration of the access.
    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic       skip;
        logic       is_store;
    } mem_ctrl_t;

    // Byte enables for up to an 8-lane bus; 4-lane callers pass off[2]=0
    // and use the low nibble. A dword on a 4-lane bus degrades to a word.
    function automatic logic [7:0] gen_be(input logic [1:0] size,
                                          input logic [2:0] off,
                                          input logic       is64);
        logic [7:0] be;
        case (size)
            SZ_BYTE: be = 8'h01 << off;
            SZ_HALF: be = 8'h03 << {off[2:1], 1'b0};
            SZ_WORD: be = 8'h0F << {off[2], 2'b00};
            default: be = is64 ? 8'hFF : 8'h0F;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Purpose : extract the addressed bytes of a bus read word, shift to bit 0, sign/zero extend.
// Latency : combinational.
// Backpressure: none.
// Ports: rdata (bus read word), off (lane offset), size/sgn (access size, sign-extend), data (result).
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter  int DW = 32,
    localparam int OW = $clog2(DW/8)
) (
    input  logic [DW-1:0] rdata,
    input  logic [OW-1:0] off,
    input  logic [1:0]    size,
    input  logic          sgn,
    output logic [DW-1:0] data
);

    logic [OW-1:0] amask;
    logic [OW-1:0] aoff;
    logic [DW-1:0] sh;
    logic [DW-1:0] mask;
    logic          sb;

    always_comb begin
        // Offset bits below the access size are dropped: accesses align down.
        amask = '1;
        case (size)
            SZ_BYTE: amask = '1;
            SZ_HALF: amask = ~OW'(1);
            SZ_WORD: amask = ~OW'(3);
            default: amask = '0;
        endcase
        aoff = off & amask;
        sh   = rdata >> {aoff, 3'b000};

        mask = '1;
        sb   = 1'b0;
        case (size)
            SZ_BYTE: begin mask = DW'(8'hFF);   sb = sh[7];  end
            SZ_HALF: begin mask = DW'(16'hFFFF); sb = sh[15]; end
            default: begin
                if (DW == 64 && size == SZ_DWORD) begin
                    mask = '1;
                    sb   = 1'b0;
                end else begin
                    // Word: sign-extends to 64 on a wide bus, no-op on a 32-bit one.
                    mask = DW'(32'hFFFF_FFFF);
                    sb   = sh[31];
                end
            end
        endcase
        data = (sh & mask) | ({DW{sgn & sb}} & ~mask);
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Purpose : pipeline memory stage, valid/ready front end, req/ack data bus, one bus op per instruction.
// Latency : 1 cycle non-memory; 2 + wait cycles for a memory op.
// Backpressure: in_ready low while a bus transaction is outstanding.
// Ports: in_* / addr_in / store_data_in / wr_reg_in / wb_ctrl_in / pc_seq_in / mem_* from execute;
//        bus_* to the data memory; out_valid / result_out / wr_reg_out / wb_ctrl_out / pc_seq_out /
//        misaligned_out to writeback. Optional MEM_STAGE_ALIGN_CHECK_EN faults misaligned accesses.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int RW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   addr_in,
    input  logic [DW-1:0]   store_data_in,
    input  logic [RW-1:0]   wr_reg_in,
    input  logic [1:0]      wb_ctrl_in,
    input  logic [AW-1:0]   pc_seq_in,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [1:0]      mem_size,
    input  logic            mem_signed,
    input  logic            skip_mem,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_be,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata,
    output logic            out_valid,
    output logic [DW-1:0]   result_out,
    output logic [RW-1:0]   wr_reg_out,
    output logic [1:0]      wb_ctrl_out,
    output logic [AW-1:0]   pc_seq_out,
    output logic            misaligned_out
);

    localparam int OW   = $clog2(DW/8);
    localparam bit IS64 = (DW == 64);

    state_t        state;
    logic [AW-1:0] addr_q;
    mem_ctrl_t     ctrl_q;
    logic [DW-1:0] load_data;
    logic [2:0]    off3;
    logic [7:0]    be8;
    logic [DW-1:0] wdata_fmt;
    logic          is_mem;
    logic          align_fault;

    // Depends on registered state only, so bus_ack never reaches in_ready.
    assign in_ready = (state != ST_BUS);
    assign is_mem   = mem_rd | mem_wr;
    assign off3     = 3'(addr_in[OW-1:0]);
    assign be8      = gen_be(mem_size, off3, IS64);

    always_comb begin
        wdata_fmt = store_data_in;
        case (mem_size)
            SZ_BYTE: wdata_fmt = {(DW/8){store_data_in[7:0]}};
            SZ_HALF: wdata_fmt = {(DW/16){store_data_in[15:0]}};
            SZ_WORD: wdata_fmt = {(DW/32){store_data_in[31:0]}};
            default: wdata_fmt = store_data_in;
        endcase
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    always_comb begin
        align_fault = 1'b0;
        case (mem_size)
            SZ_BYTE: align_fault = 1'b0;
            SZ_HALF: align_fault = addr_in[0];
            SZ_WORD: align_fault = |addr_in[1:0];
            default: align_fault = IS64 ? |addr_in[2:0] : |addr_in[1:0];
        endcase
        align_fault = align_fault & is_mem;
    end
`else
    assign align_fault = 1'b0;
`endif

    mem_load_align #(.DW(DW)) u_load_align (
        .rdata (bus_rdata),
        .off   (addr_q[OW-1:0]),
        .size  (ctrl_q.size),
        .sgn   (ctrl_q.sgn),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            ctrl_q         <= '0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_be         <= '0;
            out_valid      <= 1'b0;
            result_out     <= '0;
            wr_reg_out     <= '0;
            wb_ctrl_out    <= '0;
            pc_seq_out     <= '0;
            misaligned_out <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            misaligned_out <= 1'b0;
            case (state)
                ST_BUS: begin
                    // Request and its attributes stay put until the ack is sampled.
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        out_valid  <= 1'b1;
                        result_out <= (ctrl_q.is_store || ctrl_q.skip) ? DW'(addr_q) : load_data;
                        state      <= ST_DONE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        addr_q      <= addr_in;
                        ctrl_q      <= '{size: mem_size, sgn: mem_signed, skip: skip_mem,
                                         is_store: mem_wr};
                        wr_reg_out  <= wr_reg_in;
                        wb_ctrl_out <= wb_ctrl_in;
                        pc_seq_out  <= pc_seq_in;
                        if (align_fault) begin
                            out_valid      <= 1'b1;
                            misaligned_out <= 1'b1;
                            result_out     <= DW'(addr_in);
                            state          <= ST_DONE;
                        end else if (is_mem) begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_wr;
                            bus_addr  <= {addr_in[AW-1:OW], {OW{1'b0}}};
                            bus_be    <= be8[DW/8-1:0];
                            bus_wdata <= wdata_fmt;
                            state     <= ST_BUS;
                        end else begin
                            out_valid  <= 1'b1;
                            result_out <= DW'(addr_in);
                            state      <= ST_DONE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
